// File: rtl/signal_delay_pkg.sv
// Shared helpers for the tick-enabled delay line.
// Holds the parameter legality check used at elaboration.
package signal_delay_pkg;

   localparam int MIN_LENGTH = 1;
   localparam int MIN_WIDTH  = 1;

   function automatic bit params_valid(input int width, input int length);
      return (width >= MIN_WIDTH) && (length >= MIN_LENGTH);
   endfunction

endpackage

// File: rtl/signal_delay.sv
// Tick-enabled shift-register delay for a P_width-bit bus over P_length stages.
// The output comes straight from the last stage, so it has no combinational input path.
module signal_delay
   import signal_delay_pkg::*;
#(
   parameter int                 P_width       = 1,
   parameter int                 P_length      = 1,
   parameter logic [P_width-1:0] P_reset_value = '0
) (
   input  logic               I_clock,
   input  logic               I_reset,
   input  logic               I_tick,
   input  logic [P_width-1:0] I_signal,
   output logic [P_width-1:0] O_signal
);

   generate
      if (!params_valid(P_width, P_length)) begin : g_bad_params
         $error("signal_delay: P_width and P_length must both be at least 1");
      end
   endgenerate

   logic [P_width-1:0] stage_q [P_length];

   // Reset wins over tick; without a tick every stage holds.
   always_ff @(posedge I_clock) begin
      if (I_reset) begin
         for (int k = 0; k < P_length; k++) begin
            stage_q[k] <= P_reset_value;
         end
      end else if (I_tick) begin
         stage_q[0] <= I_signal;
         for (int k = 1; k < P_length; k++) begin
            stage_q[k] <= stage_q[k-1];
         end
      end
   end

   assign O_signal = stage_q[P_length-1];

endmodule

// File: tb/tb_signal_delay.sv
// Randomized and directed checks of signal_delay against a queue-based reference
// model, covering three parameterizations sharing one stimulus stream.
module tb_signal_delay;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic [7:0] sig;
   logic [1:0] out_a;
   logic [1:0] out_b;
   logic [7:0] out_c;

   int n_checks = 0;
   int n_fail   = 0;
   bit model_ok = 1'b0;

   // Reference: each model is the list of the last P_length ticked samples, oldest first.
   logic [1:0] qa [$];
   logic [1:0] qb [$];
   logic [7:0] qc [$];

   always #5 clk = ~clk;

   signal_delay #(.P_width(2), .P_length(4), .P_reset_value(2'b00)) u_a (
      .I_clock(clk), .I_reset(rst), .I_tick(tick), .I_signal(sig[1:0]), .O_signal(out_a)
   );

   signal_delay #(.P_width(2), .P_length(1), .P_reset_value(2'b10)) u_b (
      .I_clock(clk), .I_reset(rst), .I_tick(tick), .I_signal(sig[1:0]), .O_signal(out_b)
   );

   signal_delay #(.P_width(8), .P_length(5), .P_reset_value(8'hA5)) u_c (
      .I_clock(clk), .I_reset(rst), .I_tick(tick), .I_signal(sig), .O_signal(out_c)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cycle(input logic r, input logic t, input logic [7:0] s);
      rst  = r;
      tick = t;
      sig  = s;
      @(posedge clk);
      if (r) begin
         qa = {}; qb = {}; qc = {};
         repeat (4) qa.push_back(2'b00);
         qb.push_back(2'b10);
         repeat (5) qc.push_back(8'hA5);
         model_ok = 1'b1;
      end else if (t && model_ok) begin
         qa.push_back(s[1:0]); void'(qa.pop_front());
         qb.push_back(s[1:0]); void'(qb.pop_front());
         qc.push_back(s);      void'(qc.pop_front());
      end
      #1;
      if (model_ok) begin
         check("len4_w2", {6'b0, out_a}, {6'b0, qa[0]});
         check("len1_w2", {6'b0, out_b}, {6'b0, qb[0]});
         check("len5_w8", out_c, qc[0]);
      end
   endtask

   initial begin
      logic [1:0] frozen;
      rst = 1'b0; tick = 1'b0; sig = '0;
      @(posedge clk); #1;

      // Reset for two cycles with all-ones on the input and tick high.
      cycle(1'b1, 1'b1, 8'hFF);
      cycle(1'b1, 1'b1, 8'hFF);
      check("reset_out_a", {6'b0, out_a}, 8'h00);
      check("reset_out_c", out_c, 8'hA5);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 8'hFF);
         check("post_reset_hold", {6'b0, out_a}, 8'h00);
      end
      cycle(1'b0, 1'b1, 8'hFF);
      check("first_arrival", {6'b0, out_a}, 8'h03);
      repeat (4) cycle(1'b0, 1'b1, 8'h00);

      // Single-cycle pulse with tick tied high: appears only after the 4th edge.
      cycle(1'b0, 1'b1, 8'h01);
      for (int i = 1; i < 7; i++) begin
         cycle(1'b0, 1'b1, 8'h00);
         check("pulse_timing", {6'b0, out_a}, (i == 3) ? 8'h01 : 8'h00);
      end

      // Tick every 4th cycle; the sample must hold for exactly four clocks.
      for (int n = 0; n < 6; n++) begin
         for (int c = 0; c < 4; c++) begin
            cycle(1'b0, (c == 0), (n == 0 && c == 0) ? 8'h02 : 8'($urandom));
            if (n == 3) check("sparse_tick", {6'b0, out_a}, 8'h02);
         end
      end

      // No tick for 20 cycles while the input toggles.
      frozen = out_a;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b0, 8'($urandom));
         check("frozen", {6'b0, out_a}, {6'b0, frozen});
      end

      // In-flight values are discarded by reset.
      repeat (4) cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h01);
      cycle(1'b0, 1'b1, 8'h02);
      cycle(1'b0, 1'b1, 8'h03);
      cycle(1'b1, 1'b1, 8'h03);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, 8'h00);
         check("flushed", {6'b0, out_a}, 8'h00);
      end

      // Single-stage instance: direct tick register with nonzero reset value.
      cycle(1'b0, 1'b1, 8'h00);
      check("len1_zero", {6'b0, out_b}, 8'h00);
      cycle(1'b0, 1'b1, 8'h03);
      check("len1_ones", {6'b0, out_b}, 8'h03);
      cycle(1'b1, 1'b1, 8'h01);
      check("len1_reset", {6'b0, out_b}, 8'h02);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1, 8'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/signal_delay.md
SIGNAL_DELAY -- requirements
Module: signal_delay

Interface
- REQ-001 Parameter P_width, default 1: number of bits carried in parallel (must be 1 or more).
- REQ-002 Parameter P_length, default 1: number of tick-advanced stages (must be 1 or more); 0 shall be an elaboration error.
- REQ-003 Parameter P_reset_value, default 0, P_width bits wide: value loaded into every stage on reset.
- REQ-004 I_clock  in  1  single system clock; all state updates on rising edge.
- REQ-005 I_reset  in  1  reset, synchronous and active-high.
- REQ-006 I_tick  in  1  advance enable; the pipeline shifts only on clock edges where it is 1.
- REQ-007 I_signal  in  P_width  bus to be delayed; sampled only on tick edges.
- REQ-008 O_signal  out  P_width  delayed bus, driven directly from the last stage register.

Function
- REQ-009 Storage shall be P_length registers S[0..P_length-1], each P_width bits; O_signal = S[P_length-1].
- REQ-010 On a rising edge with I_reset=0 and I_tick=1: S[0] <= I_signal and S[k] <= S[k-1] for k = 1..P_length-1, all simultaneously.
- REQ-011 On a rising edge with I_reset=0 and I_tick=0, every stage shall hold its value and O_signal shall not change.
- REQ-012 Latency: a value on I_signal at tick edge n shall appear on O_signal immediately after tick edge n+P_length-1, i.e. P_length tick edges including the capturing edge.
- REQ-013 With I_tick tied high, the delay shall equal exactly P_length I_clock cycles.
- REQ-014 Clock cycles without a tick shall not count toward latency. The number of cycles between ticks is irrelevant, including irregular spacing.
- REQ-015 All P_width bits shall be delayed identically, with no skew between bits.
- REQ-016 O_signal shall have no combinational path from I_signal, I_tick or I_reset.
- REQ-017 When P_length=1, the block shall reduce to a single tick-enabled register.

Reset
- REQ-018 On a rising edge with I_reset=1, every stage shall load P_reset_value, regardless of I_tick.
- REQ-019 After reset, O_signal shall equal P_reset_value until P_length tick edges have occurred.
- REQ-020 Reset asserted mid-operation shall discard all in-flight values; none may emerge afterwards.
- REQ-021 Reset shall take priority over tick on the same edge.

Structure
- REQ-022 No shared package is required; all widths derive from the parameters.
- REQ-023 The design shall be a single module with no sub-modules; the stages shall be implemented as a parameterized register array or generate loop.
- REQ-024 The block shall be usable for multi-bit sync groups, e.g. {vsync, hsync} with P_width=2, P_length=4, ticked by a video-clock rising-edge strobe.

Verification
- REQ-025 P_width=2, P_length=4, I_signal=2'b11, I_reset=1 for 2 cycles -> O_signal=2'b00 throughout and for 3 further tick edges after release.
- REQ-026 I_tick=1 constantly, I_signal=2'b01 for a single cycle at edge 0, else 2'b00 -> O_signal=2'b01 only during the cycle after edge 3; 2'b00 at all other times.
- REQ-027 I_tick pulsed every 4th cycle, I_signal=2'b10 at one tick -> O_signal=2'b10 after the 4th tick, held for exactly 4 clocks, and unchanged between ticks.
- REQ-028 I_tick=0 for 20 cycles while I_signal toggles -> O_signal frozen at its prior value.
- REQ-029 Stream 2'b01,2'b10,2'b11 with I_tick=1, then I_reset=1 on the next edge -> O_signal=2'b00 afterwards, and none of 01/10/11 ever appears on the output.
- REQ-030 P_length=1, I_tick=1, I_signal changes 00->11 -> O_signal=11 on the next edge; I_reset=1 with I_tick=1 on one edge -> stages load P_reset_value.
